vector_reduce_unit: RTL and testbench
=====================================

# vector_reduce_unit

Pipelined lane-reduction stage that sits directly downstream of the input buffer and consumes its `valid/eof/vector/chainId` stream. Each accepted vector is passed through unchanged, reduced to a lane sum, or reduced to a signed lane maximum, selected by a run-time mode register. The result is emitted with a fixed latency to the next trace-processing stage.

## Interface
Parameters:
- `N`, 8: lanes per vector; power of two, ≥2.
- `DATA_WIDTH`, 32: bits per lane.
- `CFG_ID`, 8'd2: `configId` value addressing this unit.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: synchronous, active-high reset.
- `valid_in`, in, 1: input vector valid.
- `eof_in`, in, 1: last vector of frame; qualified by `valid_in`.
- `chainId_in`, in, 1: chain tag; travels with the data.
- `tracing`, in, 1: high while tracing; blocks config writes.
- `configId`, in, 8: config target id.
- `configData`, in, 8: config payload; bits [1:0] are the mode.
- `vector_in`, in, `[DATA_WIDTH-1:0] x N`: input lanes.
- `valid_out`, out, 1: output valid.
- `eof_out`, out, 1: end-of-frame of output.
- `chainId_out`, out, 1: chain tag of output.
- `vector_out`, out, `[DATA_WIDTH-1:0] x N`: output lanes.

## Operation
- Mode register `mode` takes one of three values:
  - 0 `PASS`: output equals input.
  - 1 `SUM`: lane 0 carries the sum of all lanes; lanes 1..N-1 are 0.
  - 2 `MAX`: lane 0 carries the signed maximum of all lanes; lanes 1..N-1 are 0.
  - 3 is reserved and behaves as `PASS`.
- Config write: when `configId==CFG_ID` and `tracing==0`, `mode <= configData[1:0]` at the next edge. Writes while `tracing==1` are ignored.
- Mode is sampled with each vector at pipeline entry and carried alongside it. A mode change never alters vectors already in flight.
- Arithmetic:
  - `SUM` is two's-complement, wraps modulo 2^`DATA_WIDTH`, with no saturation.
  - `MAX` uses a signed compare; on ties either operand may be chosen (the values are equal).
- Reduction uses a binary tree of $clog2(N) levels, one register stage per level.
- Bubbles (`valid_in==0`) propagate as bubbles. There is no backpressure: the unit accepts one vector every cycle.
- `eof`, `chainId`, `valid` and `mode` travel in lockstep with the data.

## Timing
- Latency `LAT = $clog2(N)+1` cycles from `valid_in` to `valid_out` in every mode, including `PASS`. This is 4 for N=8.
- Throughput is one vector per cycle; back-to-back vectors produce back-to-back outputs.
- Reset values:
  - `valid_out=0`, `eof_out=0`, `chainId_out=0`, all `vector_out` lanes 0.
  - `mode=PASS`.
  - All pipeline valid bits cleared, accumulator 0.
- Reset mid-operation: every in-flight vector is dropped, with no output for it. Inputs presented in the reset cycle are discarded.
- A config write in the same cycle as `valid_in` does not affect that vector; it applies from the next vector onward.
- Output registers hold their last value when `valid_out==0`. Consumers qualify with `valid_out`.

## Configuration
- Macro `REDUCE_FRAME_ACC_EN`.
- When defined, in `SUM`/`MAX` modes, the final stage folds each reduced vector into an accumulator (sum or max):
  - Non-eof vectors produce no output.
  - The eof vector outputs accumulator ⊕ current result with `valid_out=1` and `eof_out=1`, and the accumulator clears in the same cycle.
  - Back-to-back frames therefore need no idle cycle.
  - The accumulator is preloaded with the first vector's result, so `MAX` needs no sentinel.
  - `PASS` mode never accumulates.
  - A mode change between frames is legal. A mode change mid-frame clears the accumulator when the first vector of the new mode reaches the final stage.
- When not defined, every valid vector yields one output and no accumulator exists.
- Latency is `LAT` either way.

## Structure
- Package `vector_reduce_pkg` holds:
  - `typedef enum logic [1:0] {PASS, SUM, MAX, RSVD} reduce_mode_t`.
  - A function computing `LAT` from `N`.
  - The default `CFG_ID` constant.
- Sub-module `reduce_tree_level`: one registered tree level, parameterised by input lane count and taking the mode as an input. It is instantiated $clog2(N) times via generate. Lane passthrough for `PASS` is carried in parallel registers in the top module.

## Test plan
Conditions: N=8, DATA_WIDTH=32, `CFG_ID`=2.
- **Reset**: assert `rst` with `valid_in=1` → for the following 4 cycles `valid_out=0` and all outputs 0; `mode` reads as `PASS`.
- **PASS**: vector 1..8, `valid_in=1`, `chainId_in=1` → 4 cycles later `vector_out`=1..8 and `chainId_out=1`.
- **SUM wrap**: write mode 1, then vector of all 0x80000000 → lane 0 = 0x00000000. Vector 1..8 → lane 0 = 36, lanes 1..7 = 0.
- **MAX signed**: mode 2, vector {-5,3,-1,7,0,-8,2,6} → lane 0 = 7. All-negative {-9..-2} → lane 0 = -2.
- **Config gating and in-flight mode**: write mode 1 with `tracing=1` → ignored, output is still `PASS`. Stream 4 back-to-back vectors, switching `PASS`→`SUM` after the second → first two outputs pass through, last two reduce.
- **With `REDUCE_FRAME_ACC_EN`, SUM**: three vectors of all-1s, eof on the third, immediately followed by a one-vector frame of all-2s with eof → exactly two outputs, lane 0 = 24 then 16, both with `eof_out=1`.

Source files
------------

// File: rtl/vector_reduce_pkg.sv
// Shared types and constants for the vector_reduce_unit lane-reduction pipeline.
// Mode encoding, per-stage sideband record and the latency helper live here.
package vector_reduce_pkg;

    typedef enum logic [1:0] {PASS, SUM, MAX, RSVD} reduce_mode_t;

    // Sideband that travels in lockstep with each vector through the tree.
    typedef struct packed {
        logic         valid;
        logic         eof;
        logic         chain;
        reduce_mode_t mode;
    } stage_meta_t;

    localparam logic [7:0] DEFAULT_CFG_ID = 8'd2;

    function automatic int calc_lat(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/reduce_tree_level.sv
// One registered level of the reduction tree: pairs adjacent lanes and
// registers either their wrapped sum or their signed maximum.
module reduce_tree_level
    import vector_reduce_pkg::*;
#(
    parameter int IN_LANES   = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  reduce_mode_t                            mode,
    input  logic [IN_LANES-1:0][DATA_WIDTH-1:0]     lanes_in,
    output logic [IN_LANES/2-1:0][DATA_WIDTH-1:0]   lanes_out
);

    localparam int OUT_LANES = IN_LANES / 2;

    logic [OUT_LANES-1:0][DATA_WIDTH-1:0] lanes_d;
    logic [OUT_LANES-1:0][DATA_WIDTH-1:0] lanes_q;

    always_comb begin
        lanes_d = '0;
        for (int i = 0; i < OUT_LANES; i++) begin
            if (mode == MAX) begin
                lanes_d[i] = ($signed(lanes_in[2*i]) > $signed(lanes_in[2*i+1]))
                             ? lanes_in[2*i] : lanes_in[2*i+1];
            end else begin
                lanes_d[i] = lanes_in[2*i] + lanes_in[2*i+1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q <= '0;
        end else begin
            lanes_q <= lanes_d;
        end
    end

    assign lanes_out = lanes_q;

endmodule

// File: rtl/vector_reduce_unit.sv
// Pipelined lane reduction (PASS / SUM / signed MAX) with fixed latency $clog2(N)+1.
// Define REDUCE_FRAME_ACC_EN to fold SUM/MAX results across a frame and emit only at eof.
module vector_reduce_unit
    import vector_reduce_pkg::*;
#(
    parameter int         N          = 8,
    parameter int         DATA_WIDTH = 32,
    parameter logic [7:0] CFG_ID     = DEFAULT_CFG_ID
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           valid_in,
    input  logic                           eof_in,
    input  logic                           chainId_in,
    input  logic                           tracing,
    input  logic [7:0]                     configId,
    input  logic [7:0]                     configData,
    input  logic [N-1:0][DATA_WIDTH-1:0]   vector_in,
    output logic                           valid_out,
    output logic                           eof_out,
    output logic                           chainId_out,
    output logic [N-1:0][DATA_WIDTH-1:0]   vector_out
);

    localparam int LEVELS = calc_lat(N) - 1;

    typedef logic [N-1:0][DATA_WIDTH-1:0] vec_t;

    reduce_mode_t mode_d, mode_q;
    logic         unused_cfg_bits;

    assign unused_cfg_bits = ^configData[7:2];

    always_comb begin
        mode_d = mode_q;
        if (configId == CFG_ID && !tracing) begin
            mode_d = reduce_mode_t'(configData[1:0]);
        end
    end

    // Sideband and the unreduced vector shadow the tree, one register per level.
    stage_meta_t meta_d [LEVELS];
    stage_meta_t meta_q [LEVELS];
    vec_t        pass_d [LEVELS];
    vec_t        pass_q [LEVELS];

    always_comb begin
        meta_d[0] = '{valid: valid_in, eof: eof_in, chain: chainId_in, mode: mode_q};
        pass_d[0] = vector_in;
        for (int k = 1; k < LEVELS; k++) begin
            meta_d[k] = meta_q[k-1];
            pass_d[k] = pass_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= PASS;
            for (int k = 0; k < LEVELS; k++) begin
                meta_q[k] <= '0;
                pass_q[k] <= '0;
            end
        end else begin
            mode_q <= mode_d;
            for (int k = 0; k < LEVELS; k++) begin
                meta_q[k] <= meta_d[k];
                pass_q[k] <= pass_d[k];
            end
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        logic [(N>>(k+1))-1:0][DATA_WIDTH-1:0] lanes;
        logic [(N>>k)-1:0][DATA_WIDTH-1:0]     lvl_in;
        reduce_mode_t                          lvl_mode;

        if (k == 0) begin : g_first
            assign lvl_in   = vector_in;
            assign lvl_mode = mode_q;
        end else begin : g_next
            assign lvl_in   = g_lvl[k-1].lanes;
            assign lvl_mode = meta_q[k-1].mode;
        end

        reduce_tree_level #(
            .IN_LANES   (N >> k),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_level (
            .clk       (clk),
            .rst       (rst),
            .mode      (lvl_mode),
            .lanes_in  (lvl_in),
            .lanes_out (lanes)
        );
    end

    logic [DATA_WIDTH-1:0] tree_res;
    stage_meta_t           fin;
    vec_t                  reduced;

    assign tree_res = g_lvl[LEVELS-1].lanes[0];
    assign fin      = meta_q[LEVELS-1];

    logic valid_out_d, valid_out_q;
    logic eof_out_d,   eof_out_q;
    logic chain_out_d, chain_out_q;
    vec_t vector_out_d, vector_out_q;

`ifdef REDUCE_FRAME_ACC_EN
    logic [DATA_WIDTH-1:0] acc_d, acc_q;
    logic                  acc_vld_d, acc_vld_q;
    reduce_mode_t          acc_mode_d, acc_mode_q;
`endif

    always_comb begin
        valid_out_d  = 1'b0;
        eof_out_d    = eof_out_q;
        chain_out_d  = chain_out_q;
        vector_out_d = vector_out_q;
        reduced      = '0;
        reduced[0]   = tree_res;
`ifdef REDUCE_FRAME_ACC_EN
        acc_d      = acc_q;
        acc_vld_d  = acc_vld_q;
        acc_mode_d = acc_mode_q;
        // A mode mismatch means a new frame mode: restart from this result.
        if (acc_vld_q && acc_mode_q == fin.mode) begin
            if (fin.mode == MAX) begin
                reduced[0] = ($signed(acc_q) > $signed(tree_res)) ? acc_q : tree_res;
            end else begin
                reduced[0] = acc_q + tree_res;
            end
        end
`endif
        if (fin.valid) begin
            if (fin.mode == SUM || fin.mode == MAX) begin
`ifdef REDUCE_FRAME_ACC_EN
                if (fin.eof) begin
                    valid_out_d  = 1'b1;
                    eof_out_d    = 1'b1;
                    chain_out_d  = fin.chain;
                    vector_out_d = reduced;
                    acc_d        = '0;
                    acc_vld_d    = 1'b0;
                end else begin
                    acc_d      = reduced[0];
                    acc_vld_d  = 1'b1;
                    acc_mode_d = fin.mode;
                end
`else
                valid_out_d  = 1'b1;
                eof_out_d    = fin.eof;
                chain_out_d  = fin.chain;
                vector_out_d = reduced;
`endif
            end else begin
                valid_out_d  = 1'b1;
                eof_out_d    = fin.eof;
                chain_out_d  = fin.chain;
                vector_out_d = pass_q[LEVELS-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out_q  <= 1'b0;
            eof_out_q    <= 1'b0;
            chain_out_q  <= 1'b0;
            vector_out_q <= '0;
`ifdef REDUCE_FRAME_ACC_EN
            acc_q        <= '0;
            acc_vld_q    <= 1'b0;
            acc_mode_q   <= PASS;
`endif
        end else begin
            valid_out_q  <= valid_out_d;
            eof_out_q    <= eof_out_d;
            chain_out_q  <= chain_out_d;
            vector_out_q <= vector_out_d;
`ifdef REDUCE_FRAME_ACC_EN
            acc_q        <= acc_d;
            acc_vld_q    <= acc_vld_d;
            acc_mode_q   <= acc_mode_d;
`endif
        end
    end

    assign valid_out   = valid_out_q;
    assign eof_out     = eof_out_q;
    assign chainId_out = chain_out_q;
    assign vector_out  = vector_out_q;

endmodule

// File: tb/tb_vector_reduce_unit.sv
// Self-checking bench for vector_reduce_unit (N=8, DATA_WIDTH=32, CFG_ID=2):
// constant-table vectors, hand sequences and a randomized scoreboard against a behavioural model.
module tb_vector_reduce_unit;

    localparam logic [7:0] CFG = 8'd2;

    typedef logic [7:0][31:0] vec_t;

    typedef struct {
        logic       valid;
        logic       eof;
        logic       chain;
        logic [1:0] mode;
        vec_t       vec;
    } rec_t;

    typedef struct {
        logic [1:0] mode;
        logic       chain;
        vec_t       vin;
        vec_t       vexp;
    } tv_t;

    typedef struct {
        vec_t vec;
        logic eof;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       valid_in, eof_in, chainId_in, tracing;
    logic [7:0] configId, configData;
    vec_t       vector_in;
    logic       valid_out, eof_out, chainId_out;
    vec_t       vector_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [1:0]  mode_m;
    rec_t        pipe [$];
    obs_t        obs [$];
    logic        h_eof, h_chain;
    vec_t        h_vec;
    logic        acc_has;
    logic [1:0]  acc_md;
    logic [31:0] acc_v;

    vector_reduce_unit #(
        .N          (8),
        .DATA_WIDTH (32),
        .CFG_ID     (8'd2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .eof_in      (eof_in),
        .chainId_in  (chainId_in),
        .tracing     (tracing),
        .configId    (configId),
        .configData  (configData),
        .vector_in   (vector_in),
        .valid_out   (valid_out),
        .eof_out     (eof_out),
        .chainId_out (chainId_out),
        .vector_out  (vector_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t seq_vec(input int start);
        vec_t r;
        for (int i = 0; i < 8; i++) r[i] = 32'(start + i);
        return r;
    endfunction

    function automatic vec_t fill_vec(input logic [31:0] val);
        vec_t r;
        for (int i = 0; i < 8; i++) r[i] = val;
        return r;
    endfunction

    function automatic vec_t lane0(input logic [31:0] val);
        vec_t r;
        r    = '0;
        r[0] = val;
        return r;
    endfunction

    function automatic vec_t mk_vec(input int a [8]);
        vec_t r;
        for (int i = 0; i < 8; i++) r[i] = 32'(a[i]);
        return r;
    endfunction

    function automatic logic [31:0] combine(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
        if (m == 2'd2) return ($signed(a) > $signed(b)) ? a : b;
        return a + b;
    endfunction

    // Reference result of one vector: plain loops over lanes.
    function automatic vec_t ref_out(input logic [1:0] m, input vec_t v);
        vec_t        r;
        logic [31:0] s;
        r = v;
        if (m == 2'd1) begin
            s = 32'd0;
            for (int i = 0; i < 8; i++) s = s + v[i];
            r = lane0(s);
        end else if (m == 2'd2) begin
            s = v[0];
            for (int i = 1; i < 8; i++) if ($signed(v[i]) > $signed(s)) s = v[i];
            r = lane0(s);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic ev, input logic ee, input logic ec, input vec_t evec);
        n_checks++;
        if (valid_out !== ev || eof_out !== ee || chainId_out !== ec || vector_out !== evec) begin
            n_fail++;
            $display("FAIL %s: got valid=%0b eof=%0b chain=%0b vec=%h, expected valid=%0b eof=%0b chain=%0b vec=%h",
                     name, valid_out, eof_out, chainId_out, vector_out, ev, ee, ec, evec);
        end
    endtask

    task automatic check_vec(input string name, input vec_t got, input vec_t exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // One clock: apply inputs, advance the model, compare every output against it.
    task automatic drive(input logic r, input logic v, input logic e, input logic c, input vec_t vec,
                         input logic [7:0] cid, input logic [7:0] cdat, input logic trc);
        rec_t rec;
        rec_t pop;
        logic emit;
        vec_t outv;
        logic [31:0] val;
        rst        = r;
        valid_in   = v;
        eof_in     = e;
        chainId_in = c;
        vector_in  = vec;
        configId   = cid;
        configData = cdat;
        tracing    = trc;
        rec.valid  = v;
        rec.eof    = e;
        rec.chain  = c;
        rec.mode   = mode_m;
        rec.vec    = ref_out(mode_m, vec);
        @(posedge clk);
        #1;
        if (r) begin
            mode_m  = 2'd0;
            acc_has = 1'b0;
            pipe.delete();
            for (int i = 0; i < 3; i++) pipe.push_back('{1'b0, 1'b0, 1'b0, 2'd0, '0});
            h_eof   = 1'b0;
            h_chain = 1'b0;
            h_vec   = '0;
            check("reset", 1'b0, 1'b0, 1'b0, '0);
        end else begin
            if (cid == CFG && !trc) mode_m = cdat[1:0];
            pipe.push_back(rec);
            pop  = pipe.pop_front();
            emit = pop.valid;
            outv = pop.vec;
`ifdef REDUCE_FRAME_ACC_EN
            if (pop.valid && (pop.mode == 2'd1 || pop.mode == 2'd2)) begin
                val = (acc_has && acc_md == pop.mode) ? combine(pop.mode, acc_v, pop.vec[0]) : pop.vec[0];
                if (pop.eof) begin
                    outv    = lane0(val);
                    acc_has = 1'b0;
                end else begin
                    emit    = 1'b0;
                    acc_has = 1'b1;
                    acc_v   = val;
                    acc_md  = pop.mode;
                end
            end
`else
            val = 32'd0;
`endif
            if (emit) begin
                h_eof   = pop.eof;
                h_chain = pop.chain;
                h_vec   = outv;
            end
            check("scoreboard", emit, h_eof, h_chain, h_vec);
        end
        if (valid_out === 1'b1) obs.push_back('{vector_out, eof_out});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic set_mode(input logic [1:0] m);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, CFG, {6'd0, m}, 1'b0);
    endtask

    tv_t  tbl [6];
    vec_t rv;
    vec_t exp_if [4];

    initial begin
        tbl[0] = '{2'd0, 1'b1, seq_vec(1), seq_vec(1)};
        tbl[1] = '{2'd1, 1'b0, fill_vec(32'h8000_0000), lane0(32'h0000_0000)};
        tbl[2] = '{2'd1, 1'b1, seq_vec(1), lane0(32'd36)};
        tbl[3] = '{2'd2, 1'b0, mk_vec('{-5, 3, -1, 7, 0, -8, 2, 6}), lane0(32'd7)};
        tbl[4] = '{2'd2, 1'b1, mk_vec('{-9, -8, -7, -6, -5, -4, -3, -2}), lane0(32'hFFFF_FFFE)};
        tbl[5] = '{2'd3, 1'b0, seq_vec(10), seq_vec(10)};

        mode_m  = 2'd0;
        acc_has = 1'b0;
        acc_md  = 2'd0;
        acc_v   = 32'd0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 8'h00, 8'h00, 1'b0);

        // Reset mid-stream with valid_in high: nothing in flight may emerge.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b1, 1'b1, seq_vec(40 + i), 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, seq_vec(50), CFG, 8'h01, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("reset_hold", 1'b0, 1'b0, 1'b0, '0);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1, seq_vec(1), 8'h00, 8'h00, 1'b0);
        idle(3);
        check("reset_mode_pass", 1'b1, 1'b1, 1'b1, seq_vec(1));

        for (int t = 0; t < 6; t++) begin
            set_mode(tbl[t].mode);
            drive(1'b0, 1'b1, 1'b1, tbl[t].chain, tbl[t].vin, 8'h00, 8'h00, 1'b0);
            idle(3);
            check($sformatf("table_%0d", t), 1'b1, 1'b1, tbl[t].chain, tbl[t].vexp);
        end

        set_mode(2'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, CFG, 8'h01, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b0, seq_vec(1), 8'h00, 8'h00, 1'b0);
        idle(3);
        check("trace_gate", 1'b1, 1'b1, 1'b0, seq_vec(1));

        // Mode switch lands in the same cycle as the second vector.
        obs.delete();
        drive(1'b0, 1'b1, 1'b1, 1'b1, seq_vec(1), 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, seq_vec(1), CFG,   8'h01, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, seq_vec(1), 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, seq_vec(1), 8'h00, 8'h00, 1'b0);
        idle(4);
        exp_if[0] = seq_vec(1);
        exp_if[1] = seq_vec(1);
        exp_if[2] = lane0(32'd36);
        exp_if[3] = lane0(32'd36);
        check_int("inflight_count", obs.size(), 4);
        if (obs.size() == 4) begin
            for (int k = 0; k < 4; k++) check_vec($sformatf("inflight_%0d", k), obs[k].vec, exp_if[k]);
        end

`ifdef REDUCE_FRAME_ACC_EN
        set_mode(2'd1);
        idle(1);
        obs.delete();
        drive(1'b0, 1'b1, 1'b0, 1'b0, fill_vec(32'd1), 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, fill_vec(32'd1), 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, fill_vec(32'd1), 8'h00, 8'h00, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, fill_vec(32'd2), 8'h00, 8'h00, 1'b0);
        idle(5);
        check_int("acc_count", obs.size(), 2);
        if (obs.size() == 2) begin
            check_vec("acc_frame0", obs[0].vec, lane0(32'd24));
            check_vec("acc_frame1", obs[1].vec, lane0(32'd16));
            check_int("acc_eof0", int'(obs[0].eof), 1);
            check_int("acc_eof1", int'(obs[1].eof), 1);
        end
`endif

        for (int i = 0; i < 400; i++) begin
            for (int l = 0; l < 8; l++) begin
                rv[l] = ($urandom_range(0, 3) == 0) ? $urandom : (32'($urandom_range(0, 20)) - 32'd10);
            end
            drive($urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  1'($urandom), rv, 8'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 3) == 0);
        end
        idle(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
